// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback-side signal bundle for the pipeline hazard controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface pipe_hazard_ctrl_if;
  logic       dc_valid;
  logic [4:0] dc_rs0;
  logic [4:0] dc_rs1;
  logic [4:0] dc_rd;
  logic       dc_regwrite;
  logic       dc_ldst_ec;
  logic       dc_is_ecall;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       mem_done;
  logic       ecall_done;
  logic       o_dc_stall;
  logic       o_undo_ldst_ec_stall;
  logic       o_busy;
  logic [1:0] o_state;
  logic       o_sb_err;

  modport master (
    output dc_valid, dc_rs0, dc_rs1, dc_rd, dc_regwrite, dc_ldst_ec, dc_is_ecall,
    output wb_valid, wb_rd, mem_done, ecall_done,
    input  o_dc_stall, o_undo_ldst_ec_stall, o_busy, o_state, o_sb_err
  );

  modport slave (
    input  dc_valid, dc_rs0, dc_rs1, dc_rd, dc_regwrite, dc_ldst_ec, dc_is_ecall,
    input  wb_valid, wb_rd, mem_done, ecall_done,
    output o_dc_stall, o_undo_ldst_ec_stall, o_busy, o_state, o_sb_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side sequencing controller: per-register pending-write scoreboard for
// RAW / WAW-overflow stalls, plus a small FSM serialising load/store/ecall.
module pipe_hazard_ctrl #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_EC  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic            ec_seen_q, ec_seen_d;
  logic            sb_err_q, sb_err_d;
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];

  logic raw_s, ovf_s, stall_s, issue_s;
  logic any_pend_s, any_pend_next_s;

  // Hazard terms look only at registered counts: a same-cycle writeback is not forwarded.
  always_comb begin
    raw_s = ((bus.dc_rs0 != 5'd0) && (cnt_q[bus.dc_rs0] != CNT_ZERO)) ||
            ((bus.dc_rs1 != 5'd0) && (cnt_q[bus.dc_rs1] != CNT_ZERO));
    ovf_s = bus.dc_regwrite && (bus.dc_rd != 5'd0) && (cnt_q[bus.dc_rd] == CNT_MAX);
    stall_s = bus.dc_valid && (raw_s || ovf_s || (state_q != IDLE));
    issue_s = bus.dc_valid && !stall_s;
  end

  always_comb begin
    logic inc_v;
    logic dec_v;
    inc_v           = 1'b0;
    dec_v           = 1'b0;
    sb_err_d        = sb_err_q;
    any_pend_s      = 1'b0;
    any_pend_next_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        inc_v = issue_s && bus.dc_regwrite && (bus.dc_rd == 5'(r));
        dec_v = bus.wb_valid && (bus.wb_rd == 5'(r));
        if (inc_v && !dec_v) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (dec_v && !inc_v) begin
          if (cnt_q[r] == CNT_ZERO) begin
            sb_err_d = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
          end
        end else begin
          cnt_d[r] = cnt_q[r];
        end
      end else begin
        cnt_d[r] = CNT_ZERO;
      end
      any_pend_s      = any_pend_s || (cnt_q[r] != CNT_ZERO);
      any_pend_next_s = any_pend_next_s || (cnt_d[r] != CNT_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ec_seen_q <= 1'b0;
      sb_err_q  <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
    end else begin
      state_q   <= state_d;
      ec_seen_q <= ec_seen_d;
      sb_err_q  <= sb_err_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // WAIT_EC exits once the handler is done and the scoreboard drains, counting this cycle's writeback.
  always_comb begin
    state_d   = state_q;
    ec_seen_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_s && bus.dc_ldst_ec) begin
          state_d = bus.dc_is_ecall ? WAIT_EC : WAIT_MEM;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_done) begin
          state_d = RELEASE;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      WAIT_EC: begin
        if ((ec_seen_q || bus.ecall_done) && !any_pend_next_s) begin
          state_d   = RELEASE;
          ec_seen_d = 1'b0;
        end else begin
          state_d   = WAIT_EC;
          ec_seen_d = ec_seen_q || bus.ecall_done;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.o_dc_stall           = stall_s;
    bus.o_undo_ldst_ec_stall = (state_q == RELEASE);
    bus.o_busy               = (state_q != IDLE) || any_pend_s;
    bus.o_state              = state_q;
    bus.o_sb_err             = sb_err_q;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller sitting beside the decode stage. It keeps a register scoreboard of in-flight writes and detects RAW hazards and WAW counter overflow against the instruction in decode. It serialises load/store/ecall instructions with a small FSM and drives decode's stall input and its undo-ld/st/ecall-stall release pulse.

Parameters:
NREG, 32, number of architectural integer registers tracked (x0 never tracked)
CNTW, 2, width of per-register pending-write counter (max pending = 2^CNTW-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dc_valid  in  1  decode holds a valid instruction this cycle
dc_rs0  in  5  source register 0 of decode instruction
dc_rs1  in  5  source register 1 of decode instruction
dc_rd  in  5  destination register of decode instruction
dc_regwrite  in  1  decode instruction writes dc_rd
dc_ldst_ec  in  1  decode instruction is load, store or ecall
dc_is_ecall  in  1  decode instruction is ecall (implies dc_ldst_ec)
wb_valid  in  1  writeback retires a register write this cycle
wb_rd  in  5  register retired by writeback
mem_done  in  1  outstanding load/store completed
ecall_done  in  1  ecall handler completed
o_dc_stall  out  1  to decode dc_stall (combinational)
o_undo_ldst_ec_stall  out  1  to decode dc_undo_ldst_ec_stall (registered, 1-cycle pulse)
o_busy  out  1  any scoreboard count nonzero or FSM not IDLE
o_state  out  2  FSM state encoding: IDLE=0, WAIT_MEM=1, WAIT_EC=2, RELEASE=3
o_sb_err  out  1  sticky: writeback retired a register whose count was 0

Behaviour:
- Reset (sync, active-high): all counters 0; state IDLE; o_undo_ldst_ec_stall 0; o_sb_err 0. Reset mid-operation discards pending ops without a release pulse.
- Issue condition: issue = dc_valid && !o_dc_stall.
- Scoreboard update, per register r (1..NREG-1), each clock:
  - inc when issue && dc_regwrite && dc_rd==r; dec when wb_valid && wb_rd==r.
  - inc and dec together: count unchanged.
  - dec at count 0: count stays 0; o_sb_err set.
  - rd==0 and wb_rd==0 are ignored.
- Hazard terms, combinational from current registered counts:
  - raw = (rs0!=0 && cnt[rs0]!=0) || (rs1!=0 && cnt[rs1]!=0)
  - ovf = dc_regwrite && dc_rd!=0 && cnt[dc_rd]==max
  - A writeback in the same cycle does not clear raw; release occurs the following cycle (no forwarding).
- Stall: o_dc_stall = dc_valid && (raw || ovf || state!=IDLE). When dc_valid=0, o_dc_stall=0.
- FSM, Moore; o_undo_ldst_ec_stall = (state==RELEASE):
  - IDLE: issue && dc_ldst_ec && dc_is_ecall -> WAIT_EC; issue && dc_ldst_ec && !dc_is_ecall -> WAIT_MEM; otherwise stay. mem_done/ecall_done ignored.
  - WAIT_MEM: mem_done -> RELEASE; otherwise stay.
  - WAIT_EC: ecall_done latched into flag ec_seen; when ec_seen (or ecall_done this cycle) and all counts zero -> RELEASE. Clear ec_seen on exit.
  - RELEASE: unconditionally -> IDLE after one cycle.
- Latency: load issue at cycle N, mem_done at M gives undo pulse at M+1 and earliest next issue at M+2.
- o_busy = (state!=IDLE) || any cnt!=0.

Test Plan:
- Reset with wb_valid=1, wb_rd=5 asserted -> all counts 0, o_state=0, o_sb_err=0, o_undo_ldst_ec_stall=0.
- Issue addi x5 (cycle 0), then add x6,x5,x1 (cycle 1) -> o_dc_stall=1. Writeback x5 at cycle 3 -> stall still 1 at cycle 3, 0 at cycle 4, issue at cycle 4.
- Three writes to x7 issued with no writeback, fourth write to x7 -> o_dc_stall=1 (ovf). One wb x7 -> fourth issues next cycle, cnt[x7]=3.
- lw issued at cycle 0, mem_done at cycle 5 -> o_state=1 for cycles 1-5, o_undo pulse at cycle 6 only, o_state=0 at cycle 7.
- ecall with cnt[x10]=1, ecall_done at cycle 2, wb x10 at cycle 6 -> RELEASE at cycle 7, single undo pulse.
- wb_valid with wb_rd=9 while cnt[x9]=0 -> o_sb_err=1 and stays 1 until reset. Reset in WAIT_MEM -> o_state=0, no undo pulse.
